// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand/op registers feeding the ALU, per-op settle wait, Z capture
// with a busy/done handshake to the control unit.
module alu_operand_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int BASIC_WAIT  = 1,
    parameter int MULDIV_WAIT = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  y_in,
    input  logic                  start,
    input  logic [4:0]            op_in,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [4:0]            alu_op,
    input  logic [31:0]           result_low,
    input  logic [31:0]           result_high,
    output logic [31:0]           z_low,
    output logic [31:0]           z_high,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int MAX_WAIT = BASIC_WAIT > MULDIV_WAIT ? BASIC_WAIT : MULDIV_WAIT;
    localparam int CW = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] y_q, y_d, b_q, b_d;
    logic [4:0]            op_q, op_d;
    logic [63:0]           z_q, z_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  legal, muldiv;

    assign legal  = op_in < 5'd6;
    assign muldiv = op_in == 5'd4 || op_in == 5'd5;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        b_d     = b_q;
        op_d    = op_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_q == SETTLE) begin
            // Operands are frozen here so the ALU sees stable inputs until capture.
            if (cnt_q == '0) begin
                z_d     = {result_high, result_low};
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            state_d = IDLE;
            if (y_in) y_d = bus_in;
            if (start) begin
                b_d     = bus_in;
                op_d    = op_in;
                err_d   = !legal;
                cnt_d   = muldiv ? CW'(MULDIV_WAIT - 1) : CW'(BASIC_WAIT - 1);
                state_d = legal ? SETTLE : DONE;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            y_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            b_q     <= b_d;
            op_q    <= op_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign alu_a  = y_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;
    assign z_low  = z_q[31:0];
    assign z_high = z_q[63:32];
    assign busy   = state_q == SETTLE;
    assign done   = state_q == DONE;
    assign err    = err_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors against alu_operand_stage with a behavioural ALU
// attached; inputs driven and outputs sampled on the falling clock edge.
module tb_alu_operand_stage;
    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] bus_in;
    logic        y_in, start;
    logic [4:0]  op_in;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [31:0] result_low, result_high;
    logic [31:0] z_low, z_high;
    logic        busy, done, err;
    logic [63:0] alu_res;
    int          checks = 0;
    int          errors = 0;

    alu_operand_stage #(.DATA_WIDTH(32), .BASIC_WAIT(1), .MULDIV_WAIT(4)) dut (
        .clock(clock), .clear(clear), .bus_in(bus_in), .y_in(y_in), .start(start),
        .op_in(op_in), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .result_low(result_low), .result_high(result_high), .z_low(z_low),
        .z_high(z_high), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            5'd0: alu_res = {32'd0, alu_a | alu_b};
            5'd1: alu_res = {32'd0, alu_a & alu_b};
            5'd2: alu_res = {32'd0, alu_a + alu_b};
            5'd3: alu_res = {32'd0, alu_a - alu_b};
            5'd4: alu_res = {32'd0, alu_a} * {32'd0, alu_b};
            5'd5: alu_res = alu_b == 0 ? 64'd0 : {alu_a % alu_b, alu_a / alu_b};
            default: alu_res = '0;
        endcase
    end
    assign result_low  = alu_res[31:0];
    assign result_high = alu_res[63:32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic y, input logic s, input logic [4:0] op, input logic [31:0] bus);
        y_in = y; start = s; op_in = op; bus_in = bus;
    endtask

    initial begin
        clear = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clock);
        check("rst_z", {z_high, z_low}, 64'd0);
        check("rst_hs", {busy, done, err}, 3'b000);
        check("rst_ops", {alu_a, alu_b}, 64'd0);
        clear = 1'b1;

        // add 7+5
        @(negedge clock) drive(1, 0, 0, 32'd7);
        @(negedge clock) drive(0, 1, 5'd2, 32'd5);
        @(negedge clock) drive(0, 0, 0, 0);
        check("add_busy", {busy, done}, 2'b10);
        check("add_ops", {alu_a, alu_b, 27'd0, alu_op}, {32'd7, 32'd5, 32'd2});
        @(negedge clock);
        check("add_done", {busy, done, err}, 3'b010);
        check("add_z", {z_high, z_low}, 64'd12);
        @(negedge clock);
        check("add_done_drop", {busy, done}, 2'b00);
        check("add_z_hold", {z_high, z_low}, 64'd12);

        // mul 0x10000*0x10000 with a start injected mid-settle
        @(negedge clock) drive(1, 0, 0, 32'h0001_0000);
        @(negedge clock) drive(0, 1, 5'd4, 32'h0001_0000);
        @(negedge clock) drive(0, 0, 0, 0);
        check("mul_busy1", {busy, done}, 2'b10);
        @(negedge clock) drive(0, 1, 5'd2, 32'd1);
        check("mul_busy2", {busy, done}, 2'b10);
        @(negedge clock) drive(0, 0, 0, 0);
        check("mul_busy3", {busy, done}, 2'b10);
        check("mul_ignore", {alu_b, 27'd0, alu_op}, {32'h0001_0000, 32'd4});
        @(negedge clock);
        check("mul_busy4", {busy, done}, 2'b10);
        check("mul_z_pre", {z_high, z_low}, 64'd12);
        @(negedge clock);
        check("mul_done", {busy, done}, 2'b01);
        check("mul_z", {z_high, z_low}, 64'h0000_0001_0000_0000);
        @(negedge clock);
        check("mul_done_drop", {busy, done}, 2'b00);

        // operand hold: y_in during settle must not disturb Y
        @(negedge clock) drive(0, 1, 5'd2, 32'd1);
        @(negedge clock) drive(1, 0, 0, 32'h0000_FFFF);
        @(negedge clock) drive(0, 0, 0, 0);
        check("hold_a", alu_a, 64'h0001_0000);
        check("hold_z", {z_high, z_low}, 64'h0001_0001);
        check("hold_done", done, 1'b1);

        // illegal op
        @(negedge clock) drive(0, 1, 5'd9, 32'h55);
        @(negedge clock) drive(0, 0, 0, 0);
        check("ill_hs", {busy, done, err}, 3'b011);
        check("ill_op", {alu_b, 27'd0, alu_op}, {32'h55, 32'd9});
        check("ill_z", {z_high, z_low}, 64'h0001_0001);
        @(negedge clock);
        check("ill_err_hold", {busy, done, err}, 3'b001);

        // shared bus y_in+start, then back-to-back start in DONE
        @(negedge clock) drive(1, 1, 5'd3, 32'd3);
        @(negedge clock) drive(0, 0, 0, 0);
        check("sq_hs", {busy, done, err}, 3'b100);
        check("sq_ops", {alu_a, alu_b}, {32'd3, 32'd3});
        @(negedge clock);
        check("sq_done", {busy, done}, 2'b01);
        check("sq_z", {z_high, z_low}, 64'd0);
        drive(0, 1, 5'd0, 32'h0000_00F0);
        @(negedge clock) drive(0, 0, 0, 0);
        check("b2b_busy", {busy, done}, 2'b10);
        @(negedge clock);
        check("b2b_done", {busy, done}, 2'b01);
        check("b2b_z", {z_high, z_low}, 64'h0000_00F3);

        // async reset mid mul-settle
        @(negedge clock) drive(0, 1, 5'd4, 32'd2);
        @(negedge clock) drive(0, 0, 0, 0);
        @(negedge clock);
        check("ar_pre_busy", busy, 1'b1);
        #2 clear = 1'b0;
        #1;
        check("ar_z", {z_high, z_low}, 64'd0);
        check("ar_hs", {busy, done, err}, 3'b000);
        check("ar_ops", {alu_a, alu_b, 27'd0, alu_op}, 96'd0);
        @(negedge clock) clear = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("ar_quiet", {busy, done}, 2'b00);
        end
        check("ar_z_after", {z_high, z_low}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Datapath stage wrapped around the combinational ALU.
- Upstream side: holds operand A in the Y register (loaded from the shared data bus) and operand B plus the op code (captured on start), and drives both operands and the op code to the ALU.
- Downstream side: waits a per-op settle time (multicycle path for mul/div), then captures the ALU's result_high/result_low pair into the 64-bit Z register.
- Signals completion to the control unit with a busy/done handshake.

Parameters:
- DATA_WIDTH, 32: operand and bus width; Z halves are 32 bits each.
- BASIC_WAIT, 1: settle cycles for ops 0-3 (or/and/add/sub); must be >=1.
- MULDIV_WAIT, 4: settle cycles for ops 4-5 (mul/div); must be >=1.

Ports:
- clock  in  1  single system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- bus_in  in  DATA_WIDTH  shared data bus.
- y_in  in  1  load Y (operand A) from bus_in.
- start  in  1  capture bus_in as B and op_in as op; begin an operation.
- op_in  in  5  ALU op code: 0 or, 1 and, 2 add, 3 sub, 4 mul, 5 div.
- alu_a  out  DATA_WIDTH  Y register, to ALU A.
- alu_b  out  DATA_WIDTH  B register, to ALU B.
- alu_op  out  5  op register, to ALU op.
- result_low  in  32  from ALU.
- result_high  in  32  from ALU.
- z_low  out  32  Z register, low half.
- z_high  out  32  Z register, high half.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  last started op code was illegal.

Behaviour:
- Reset (clear=0, asynchronous): Y, B, op, Z, counter = 0; busy=0, done=0, err=0; FSM=IDLE. Reset mid-operation aborts it: Z is not updated and done is not pulsed.
- FSM states:
  - IDLE: busy=0.
  - SETTLE: busy=1, down-counter running.
  - DONE: one cycle, done=1, busy=0.
- y_in in IDLE or DONE: Y<=bus_in at the edge. Ignored in SETTLE, so operands are stable while the ALU settles.
- start in IDLE or DONE, legal op (0-5):
  - At edge k: B<=bus_in, op<=op_in, err<=0, count<=W-1, where W=MULDIV_WAIT for ops 4/5 and BASIC_WAIT otherwise. Go to SETTLE.
  - At edge k+W: Z<={result_high,result_low} sampled from the ALU inputs; go to DONE. done=1 during the cycle after edge k+W; busy=1 from edge k to edge k+W.
- start with illegal op (6-31):
  - At edge k: op and B are loaded, err<=1, go to DONE. Z is unchanged; done pulses in the following cycle.
  - err holds until the next start.
- y_in and start in the same cycle (IDLE or DONE): both Y and B load the same bus_in value. This is legal (e.g. squaring).
- start while in SETTLE: ignored, with no queuing. The control unit must wait for done.
- DONE is always followed by IDLE unless start is asserted in DONE. In that case the new operation begins directly (back-to-back) and done drops.
- alu_a/alu_b/alu_op are direct register outputs and hold their values after completion.
- z_low/z_high change only at the capture edge or on reset. No arithmetic is performed here; widths pass through unchanged.
- The counter is wide enough for max(BASIC_WAIT, MULDIV_WAIT)-1.

Test Plan:
- Reset: clear=0 mid-SETTLE of a mul -> all outputs 0 immediately (asynchronously); after release, FSM is IDLE, done never pulses.
- Add: bus_in=7 with y_in; then bus_in=5, op_in=2, start at edge k; ALU model returns 12 -> busy high for 1 cycle, z_low=12 and z_high=0 at edge k+1, done high for exactly one cycle.
- Mul latency: Y=0x0001_0000, B=0x0001_0000, op 4, MULDIV_WAIT=4 -> busy for 4 cycles, Z={0x0000_0001, 0x0000_0000} at edge k+4. A start pulse injected at k+2 is ignored.
- Illegal op: op_in=9 with start -> err=1, done pulse in the next cycle, Z keeps its previous value. A later legal start clears err.
- Back-to-back and shared bus: y_in and start together with bus_in=3, op 3 -> Y=B=3, Z=0. start asserted during DONE with op 0 and bus_in=0xF0 -> new operation begins, Z=0xF3.
- Operand hold: y_in pulsed with bus_in=0xFFFF during SETTLE -> alu_a unchanged, result uses the original Y.
